// File: rtl/bus_sequencer.sv
// bus_sequencer: fetch/decode/execute sequencer for the shared 8-bit data bus.
// Optional single-step pause state under `define STEP_MODE_EN.
`timescale 1ns/1ps
module bus_sequencer #(
    parameter int DATA_BUS_WIDTH = 8,
    parameter int SETTLE_CYCLES  = 1,
    parameter int COUNT_WIDTH    = 16
) (
    input  logic                      clock,
    input  logic                      reset_n,
    input  logic                      start,
    input  logic                      step,
    input  logic [DATA_BUS_WIDTH-1:0] inst,
    output logic [7:0]                drive_sel,
    output logic [7:0]                load_en,
    output logic [2:0]                alu_func,
    output logic                      mem_read,
    output logic                      mem_write,
    output logic                      jump,
    output logic                      busy,
    output logic                      halted,
    output logic [COUNT_WIDTH-1:0]    inst_count
);

`ifdef STEP_MODE_EN
    typedef enum logic [2:0] {S_IDLE, S_FETCH, S_EXEC, S_HALT, S_PAUSE} state_t;
    logic r_step_d;
    logic w_step_rise;
    assign w_step_rise = step & ~r_step_d;
`else
    typedef enum logic [2:0] {S_IDLE, S_FETCH, S_EXEC, S_HALT} state_t;
    logic w_unused_step;
    assign w_unused_step = step;
`endif

    state_t     r_state;
    logic [1:0] r_t;
    logic [3:0] r_settle;
    logic [7:0] r_ir;

    state_t     w_nstate;
    state_t     w_after;
    logic [1:0] w_nt;
    logic       w_retire;
    logic       w_tend;
    logic       w_active;
    logic [7:0] w_ir;
    logic       w_mov, w_alu, w_load, w_store, w_jump, w_halt, w_exec;

    logic [7:0] w_drv, w_ld;
    logic [2:0] w_alu_f;
    logic       w_mr, w_mw, w_jmp;

    assign w_tend   = (r_settle == 4'(SETTLE_CYCLES - 1));
    assign w_active = (r_state == S_FETCH) || (r_state == S_EXEC);
    // During fetch the INST register is decoded live; it is captured at F4.
    assign w_ir     = (r_state == S_FETCH) ? inst : r_ir;

    assign w_mov   = (w_ir[7:6] == 2'b00) && (w_ir[5:3] < 3'd6) &&
                     (w_ir[2:0] < 3'd6) && (w_ir[5:3] != w_ir[2:0]);
    assign w_alu   = (w_ir[7:4] == 4'b1000);
    assign w_load  = (w_ir[7:3] == 5'b10010);
    assign w_store = (w_ir[7:3] == 5'b10011);
    assign w_jump  = (w_ir[7:6] == 2'b11);
    assign w_halt  = (w_ir == 8'hAE);
    assign w_exec  = w_mov | w_alu | w_load | w_store | w_jump;

`ifdef STEP_MODE_EN
    assign w_after = S_PAUSE;
`else
    assign w_after = start ? S_FETCH : S_IDLE;
`endif

    always_comb begin
        w_nstate = r_state;
        w_nt     = r_t;
        w_retire = 1'b0;
        unique case (r_state)
            S_IDLE: begin
                if (start) begin
                    w_nstate = S_FETCH;
                    w_nt     = 2'd0;
                end
            end
            S_FETCH: begin
                if (w_tend) begin
                    if (r_t != 2'd3) begin
                        w_nt = r_t + 2'd1;
                    end else if (w_halt) begin
                        w_nstate = S_HALT;
                        w_retire = 1'b1;
                    end else if (w_exec) begin
                        w_nstate = S_EXEC;
                        w_nt     = 2'd0;
                    end else begin
                        w_nstate = w_after;
                        w_nt     = 2'd0;
                        w_retire = 1'b1;
                    end
                end
            end
            S_EXEC: begin
                if (w_tend) begin
                    if (r_t != 2'd3) begin
                        w_nt = r_t + 2'd1;
                    end else begin
                        w_nstate = w_after;
                        w_nt     = 2'd0;
                        w_retire = 1'b1;
                    end
                end
            end
            S_HALT: begin
                w_nstate = S_HALT;
            end
`ifdef STEP_MODE_EN
            S_PAUSE: begin
                if (!start) begin
                    w_nstate = S_IDLE;
                end else if (w_step_rise) begin
                    w_nstate = S_FETCH;
                    w_nt     = 2'd0;
                end
            end
`endif
            default: w_nstate = S_IDLE;
        endcase
    end

    // Outputs are decoded from the next T-state so they are registered.
    always_comb begin
        w_drv   = 8'h00;
        w_ld    = 8'h00;
        w_alu_f = 3'd0;
        w_mr    = 1'b0;
        w_mw    = 1'b0;
        w_jmp   = 1'b0;
        if (w_nstate == S_FETCH && w_nt != 2'd3) begin
            w_drv[7] = 1'b1;
            w_mr     = 1'b1;
            w_ld[7]  = (w_nt == 2'd1);
        end else if (w_nstate == S_EXEC && w_nt != 2'd3) begin
            unique case (1'b1)
                w_mov: begin
                    w_drv = 8'b1 << w_ir[2:0];
                    if (w_nt == 2'd1) w_ld = 8'b1 << w_ir[5:3];
                end
                w_alu: begin
                    w_drv[6] = 1'b1;
                    w_alu_f  = w_ir[2:0];
                    if (w_nt == 2'd1) w_ld = w_ir[3] ? 8'h08 : 8'h01;
                end
                w_load: begin
                    w_drv[7] = 1'b1;
                    w_mr     = 1'b1;
                    if (w_nt == 2'd1) w_ld = w_ir[2] ? 8'h02 : 8'h01;
                end
                w_store: begin
                    w_drv = w_ir[2] ? 8'h02 : 8'h01;
                    w_mw  = (w_nt == 2'd1);
                end
                w_jump: begin
                    w_drv[7] = 1'b1;
                    w_mr     = 1'b1;
                    w_ld[6]  = (w_nt == 2'd1);
                    w_jmp    = (w_nt == 2'd2);
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_state    <= S_IDLE;
            r_t        <= 2'd0;
            r_settle   <= 4'd0;
            r_ir       <= 8'h00;
            drive_sel  <= 8'h00;
            load_en    <= 8'h00;
            alu_func   <= 3'd0;
            mem_read   <= 1'b0;
            mem_write  <= 1'b0;
            jump       <= 1'b0;
            busy       <= 1'b0;
            halted     <= 1'b0;
            inst_count <= '0;
`ifdef STEP_MODE_EN
            r_step_d   <= 1'b0;
`endif
        end else begin
            r_state   <= w_nstate;
            r_t       <= w_nt;
            r_settle  <= (w_active && !w_tend) ? r_settle + 4'd1 : 4'd0;
            if (r_state == S_FETCH && r_t == 2'd3 && w_tend) r_ir <= inst;
            drive_sel <= w_drv;
            load_en   <= w_ld;
            alu_func  <= w_alu_f;
            mem_read  <= w_mr;
            mem_write <= w_mw;
            jump      <= w_jmp;
            busy      <= (w_nstate != S_IDLE) && (w_nstate != S_HALT);
            halted    <= (w_nstate == S_HALT);
            if (w_retire) inst_count <= inst_count + COUNT_WIDTH'(1);
`ifdef STEP_MODE_EN
            r_step_d  <= step;
`endif
        end
    end

endmodule

// File: tb/tb_bus_sequencer.sv
// Directed bench for bus_sequencer: per-T-state bus vectors, reset, halt
// and counter wrap (second instance with slow T-states and a narrow counter).
`timescale 1ns/1ps
module tb_bus_sequencer;
    logic clock = 1'b0;
    always #5 clock = ~clock;

    logic        reset_n, start, step;
    logic [7:0]  inst;
    logic [7:0]  drive_sel, load_en;
    logic [2:0]  alu_func;
    logic        mem_read, mem_write, jump, busy, halted;
    logic [15:0] inst_count;

    logic        reset_n1, start1, step1;
    logic [7:0]  inst1;
    logic [7:0]  drive_sel1, load_en1;
    logic [2:0]  alu_func1;
    logic        mem_read1, mem_write1, jump1, busy1, halted1;
    logic [3:0]  inst_count1;

    int checks = 0;
    int failures = 0;

    bus_sequencer #(.DATA_BUS_WIDTH(8), .SETTLE_CYCLES(1), .COUNT_WIDTH(16)) u0 (
        .clock(clock), .reset_n(reset_n), .start(start), .step(step),
        .inst(inst), .drive_sel(drive_sel), .load_en(load_en),
        .alu_func(alu_func), .mem_read(mem_read), .mem_write(mem_write),
        .jump(jump), .busy(busy), .halted(halted), .inst_count(inst_count)
    );

    bus_sequencer #(.DATA_BUS_WIDTH(8), .SETTLE_CYCLES(3), .COUNT_WIDTH(4)) u1 (
        .clock(clock), .reset_n(reset_n1), .start(start1), .step(step1),
        .inst(inst1), .drive_sel(drive_sel1), .load_en(load_en1),
        .alu_func(alu_func1), .mem_read(mem_read1), .mem_write(mem_write1),
        .jump(jump1), .busy(busy1), .halted(halted1), .inst_count(inst_count1)
    );

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick;
        @(posedge clock);
        #1;
    endtask

    // {drive, load, alu, mem_read, mem_write, jump, busy, halted}
    function automatic logic [31:0] vec0();
        return {8'h00, drive_sel, load_en, alu_func, mem_read, mem_write,
                jump, busy, halted};
    endfunction

    function automatic logic [31:0] vec1();
        return {8'h00, drive_sel1, load_en1, alu_func1, mem_read1, mem_write1,
                jump1, busy1, halted1};
    endfunction

    function automatic logic [31:0] mk(input logic [7:0] d, input logic [7:0] l,
                                       input logic [2:0] a, input logic r,
                                       input logic w, input logic j,
                                       input logic b, input logic h);
        return {8'h00, d, l, a, r, w, j, b, h};
    endfunction

    // Runs nk T-states of one instruction starting at the edge that enters F1.
    task automatic do_instr(input logic [7:0] in, input logic [7:0] edrv,
                            input logic [7:0] eld, input logic [2:0] ealu,
                            input logic emr, input logic emw, input logic ejmp,
                            input int ecnt, input int nk, input bit tog,
                            input string nm);
        logic [7:0] d, l;
        logic [2:0] a;
        logic r, w, j;
        int e;
        inst = in;
        for (int k = 0; k < nk; k++) begin
            tick;
            if (k < 4) begin
                d = (k < 3) ? 8'h80 : 8'h00;
                l = (k == 1) ? 8'h80 : 8'h00;
                a = 3'd0;
                r = (k < 3);
                w = 1'b0;
                j = 1'b0;
            end else begin
                e = k - 4;
                d = (e < 3) ? edrv : 8'h00;
                l = (e == 1) ? eld : 8'h00;
                a = (e < 3) ? ealu : 3'd0;
                r = (e < 3) && emr;
                w = (e == 1) && emw;
                j = (e == 2) && ejmp;
            end
            chk($sformatf("%s_t%0d", nm, k), vec0(), mk(d, l, a, r, w, j, 1'b1, 1'b0));
            if (k == 0) chk($sformatf("%s_cnt", nm), 32'(inst_count), 32'(ecnt));
            if (tog && k == 2) start = 1'b0;
            if (tog && k == 5) start = 1'b1;
        end
    endtask

    initial begin
        reset_n  = 1'b0;
        start    = 1'b0;
        step     = 1'b0;
        inst     = 8'h00;
        reset_n1 = 1'b0;
        start1   = 1'b0;
        step1    = 1'b0;
        inst1    = 8'h00;
        #22;
        reset_n = 1'b1;
        tick;
        chk("idle_vec", vec0(), 32'h0);
        chk("idle_cnt", 32'(inst_count), 32'h0);
        start = 1'b1;

        do_instr(8'h01, 8'h02, 8'h01, 3'd0, 1'b0, 1'b0, 1'b0, 0, 8, 1'b0, "mov_ab");
        do_instr(8'h85, 8'h40, 8'h01, 3'd5, 1'b0, 1'b0, 1'b0, 1, 8, 1'b1, "alu5");
        do_instr(8'h98, 8'h01, 8'h00, 3'd0, 1'b0, 1'b1, 1'b0, 2, 8, 1'b0, "store_a");
        do_instr(8'h94, 8'h80, 8'h02, 3'd0, 1'b1, 1'b0, 1'b0, 3, 8, 1'b0, "load_b");
        do_instr(8'h01, 8'h02, 8'h01, 3'd0, 1'b0, 1'b0, 1'b0, 4, 6, 1'b0, "mov_e2");

        #2;
        reset_n = 1'b0;
        #1;
        chk("rst_async_vec", vec0(), 32'h0);
        chk("rst_async_cnt", 32'(inst_count), 32'h0);
        @(negedge clock);
        reset_n = 1'b1;

        do_instr(8'hC0, 8'h80, 8'h40, 3'd0, 1'b1, 1'b0, 1'b1, 0, 8, 1'b0, "jump");
        do_instr(8'hAE, 8'h00, 8'h00, 3'd0, 1'b0, 1'b0, 1'b0, 1, 4, 1'b0, "halt_f");
        tick;
        chk("halt_vec", vec0(), mk(8'h00, 8'h00, 3'd0, 0, 0, 0, 1'b0, 1'b1));
        chk("halt_cnt", 32'(inst_count), 32'd2);
        inst = 8'h01;
        for (int i = 0; i < 10; i++) begin
            tick;
            chk($sformatf("halt_hold%0d", i), vec0(),
                mk(8'h00, 8'h00, 3'd0, 0, 0, 0, 1'b0, 1'b1));
        end
        chk("halt_hold_cnt", 32'(inst_count), 32'd2);

        @(negedge clock);
        reset_n1 = 1'b1;
        start1   = 1'b1;
        for (int n = 1; n <= 205; n++) begin
            tick;
            if (n <= 3)
                chk($sformatf("s3_f1_%0d", n), vec1(),
                    mk(8'h80, 8'h00, 3'd0, 1, 0, 0, 1'b1, 1'b0));
            else if (n <= 6)
                chk($sformatf("s3_f2_%0d", n), vec1(),
                    mk(8'h80, 8'h80, 3'd0, 1, 0, 0, 1'b1, 1'b0));
            else if (n >= 10 && n <= 12)
                chk($sformatf("s3_f4_%0d", n), vec1(),
                    mk(8'h00, 8'h00, 3'd0, 0, 0, 0, 1'b1, 1'b0));
            if (n == 12)  chk("s3_cnt12", 32'(inst_count1), 32'd0);
            if (n == 13) begin
                chk("s3_cnt13", 32'(inst_count1), 32'd1);
                chk("s3_f1_again", vec1(), mk(8'h80, 8'h00, 3'd0, 1, 0, 0, 1'b1, 1'b0));
            end
            if (n == 181) chk("s3_cnt_max", 32'(inst_count1), 32'hF);
            if (n == 193) chk("s3_cnt_wrap", 32'(inst_count1), 32'h0);
            if (n == 194) start1 = 1'b0;
            if (n == 204) chk("s3_busy_pre", 32'(busy1), 32'd1);
            if (n == 205) begin
                chk("s3_idle_vec", vec1(), 32'h0);
                chk("s3_idle_cnt", 32'(inst_count1), 32'd1);
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
